// File: rtl/sdram_pkg.sv
// Shared types and constants for the SDRAM command/pin engine.
//   op_e      : decoded command opcodes from the scheduler
//   CMD_*     : {ras_n, cas_n, we_n} pin encodings (cs_n is driven low separately)
//   cnt_w()   : width of a down-counter that is loaded with (cycles - 1)
package sdram_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_ACT  = 3'd1,
        OP_RD   = 3'd2,
        OP_WR   = 3'd3,
        OP_PRE  = 3'd4,
        OP_PREA = 3'd5,
        OP_REF  = 3'd6,
        OP_MRS  = 3'd7
    } op_e;

    localparam logic [2:0] CMD_NOP = 3'b111;
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_REF = 3'b001;
    localparam logic [2:0] CMD_MRS = 3'b000;

    // A counter loaded with cycles-1 needs enough bits to hold that value.
    function automatic int unsigned cnt_w(input int unsigned cycles);
        return (cycles < 32'd2) ? 32'd1 : int'($clog2(cycles));
    endfunction

endpackage

// File: rtl/sdram_bank_timer.sv
// Per-bank open/idle state and JEDEC spacing counters.
//   act, wr, pre : one-cycle events for this bank (already qualified by handshake)
//   is_open      : bank has an open row
//   *_ok_c       : corresponding spacing counter has reached zero
// Counters are loaded with T-1 at the handshake so the dependent command can
// handshake exactly T cycles later, in the cycle the counter reads zero.
module sdram_bank_timer
    import sdram_pkg::*;
#(
    parameter int unsigned T_RCD = 3,
    parameter int unsigned T_RP  = 3,
    parameter int unsigned T_RAS = 7,
    parameter int unsigned T_RC  = 10,
    parameter int unsigned T_WR  = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic act,
    input  logic wr,
    input  logic pre,
    output logic is_open,
    output logic rcd_ok_c,
    output logic ras_ok_c,
    output logic rc_ok_c,
    output logic rp_ok_c,
    output logic wr_ok_c
);

    localparam int unsigned RCD_W = cnt_w(T_RCD);
    localparam int unsigned RP_W  = cnt_w(T_RP);
    localparam int unsigned RAS_W = cnt_w(T_RAS);
    localparam int unsigned RC_W  = cnt_w(T_RC);
    localparam int unsigned WR_W  = cnt_w(T_WR);

    localparam logic [RCD_W-1:0] RCD_LD = RCD_W'((T_RCD > 0) ? T_RCD - 1 : 0);
    localparam logic [RP_W-1:0]  RP_LD  = RP_W'((T_RP > 0) ? T_RP - 1 : 0);
    localparam logic [RAS_W-1:0] RAS_LD = RAS_W'((T_RAS > 0) ? T_RAS - 1 : 0);
    localparam logic [RC_W-1:0]  RC_LD  = RC_W'((T_RC > 0) ? T_RC - 1 : 0);
    localparam logic [WR_W-1:0]  WR_LD  = WR_W'((T_WR > 0) ? T_WR - 1 : 0);

    logic [RCD_W-1:0] rcd_cnt;
    logic [RP_W-1:0]  rp_cnt;
    logic [RAS_W-1:0] ras_cnt;
    logic [RC_W-1:0]  rc_cnt;
    logic [WR_W-1:0]  wr_cnt;

    assign rcd_ok_c = (rcd_cnt == '0);
    assign rp_ok_c  = (rp_cnt == '0);
    assign ras_ok_c = (ras_cnt == '0);
    assign rc_ok_c  = (rc_cnt == '0);
    assign wr_ok_c  = (wr_cnt == '0);

    // Bank state and saturating down-counters
    always_ff @(posedge clk) begin
        if (rst) begin
            is_open <= 1'b0;
            rcd_cnt <= '0;
            rp_cnt  <= '0;
            ras_cnt <= '0;
            rc_cnt  <= '0;
            wr_cnt  <= '0;
        end else begin
            if (act) begin
                is_open <= 1'b1;
            end else if (pre) begin
                is_open <= 1'b0;
            end

            rcd_cnt <= act ? RCD_LD : (rcd_ok_c ? rcd_cnt : rcd_cnt - RCD_W'(1));
            ras_cnt <= act ? RAS_LD : (ras_ok_c ? ras_cnt : ras_cnt - RAS_W'(1));
            rc_cnt  <= act ? RC_LD  : (rc_ok_c  ? rc_cnt  : rc_cnt  - RC_W'(1));
            rp_cnt  <= pre ? RP_LD  : (rp_ok_c  ? rp_cnt  : rp_cnt  - RP_W'(1));
            wr_cnt  <= wr  ? WR_LD  : (wr_ok_c  ? wr_cnt  : wr_cnt  - WR_W'(1));
        end
    end

endmodule

// File: rtl/sdram_cmd_phy.sv
// SDRAM command/pin engine.
//   cmd_*      : valid/ready command port from the scheduler (cmd_ready is
//                combinational from bank state, counters and the offered op)
//   rd_valid/rd_data : read return, CAS_LAT+2 cycles after the RD handshake
//   err_illegal: one-cycle pulse when a state-illegal command is dropped
//   cke..dq_oe : registered SDRAM pins; dq_in is the pad read data
module sdram_cmd_phy
    import sdram_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ROW_W   = 13,
    parameter int unsigned COL_W   = 9,
    parameter int unsigned BANK_W  = 2,
    parameter int unsigned CAS_LAT = 3,
    parameter int unsigned T_RCD   = 3,
    parameter int unsigned T_RP    = 3,
    parameter int unsigned T_RAS   = 7,
    parameter int unsigned T_RC    = 10,
    parameter int unsigned T_WR    = 2,
    parameter int unsigned T_RFC   = 10,
    parameter int unsigned T_MRD   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  op_e                   cmd_op,
    input  logic [BANK_W-1:0]     cmd_bank,
    input  logic [ROW_W-1:0]      cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_wmask,
    output logic                  rd_valid,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  err_illegal,
    output logic                  cke,
    output logic                  cs_n,
    output logic                  ras_n,
    output logic                  cas_n,
    output logic                  we_n,
    output logic [BANK_W-1:0]     ba,
    output logic [ROW_W-1:0]      addr,
    output logic [DATA_W/8-1:0]   dqm,
    output logic [DATA_W-1:0]     dq_out,
    input  logic [DATA_W-1:0]     dq_in,
    output logic                  dq_oe
);

    localparam int unsigned NB     = 1 << BANK_W;
    localparam int unsigned GLB_T  = (T_RFC > T_MRD) ? T_RFC : T_MRD;
    localparam int unsigned GLB_W  = cnt_w(GLB_T);
    localparam logic [GLB_W-1:0] RFC_LD = GLB_W'((T_RFC > 0) ? T_RFC - 1 : 0);
    localparam logic [GLB_W-1:0] MRD_LD = GLB_W'((T_MRD > 0) ? T_MRD - 1 : 0);
    localparam logic [ROW_W-1:0] A10    = ROW_W'(32'd1 << 10);

    logic [GLB_W-1:0]  glb_cnt;
    logic [CAS_LAT:0]  rd_pipe;

    logic [NB-1:0] bank_sel_c;
    logic [NB-1:0] act_ev_c;
    logic [NB-1:0] wr_ev_c;
    logic [NB-1:0] pre_ev_c;
    logic [NB-1:0] is_open;
    logic [NB-1:0] rcd_ok_c;
    logic [NB-1:0] ras_ok_c;
    logic [NB-1:0] rc_ok_c;
    logic [NB-1:0] rp_ok_c;
    logic [NB-1:0] wr_ok_c;

    logic ok_c;
    logic illegal_c;
    logic glb_idle_c;
    logic rd_busy_c;
    logic fire_c;
    logic issue_c;
    logic drop_c;
    logic [ROW_W-1:0] col_c;

    assign glb_idle_c = (glb_cnt == '0);
    assign rd_busy_c  = |rd_pipe;
    assign col_c      = ROW_W'(cmd_addr[COL_W-1:0]);

    // One-hot decode of the addressed bank
    always_comb begin
        bank_sel_c = '0;
        bank_sel_c[cmd_bank] = 1'b1;
    end

    // Timing readiness (ok_c) versus state-illegal (illegal_c) for the offered op
    always_comb begin
        ok_c      = 1'b0;
        illegal_c = 1'b0;
        case (cmd_op)
            OP_NOP: ok_c = 1'b1;
            OP_ACT: begin
                if (is_open[cmd_bank]) illegal_c = 1'b1;
                else                   ok_c = rp_ok_c[cmd_bank] & rc_ok_c[cmd_bank];
            end
            OP_RD: begin
                if (!is_open[cmd_bank]) illegal_c = 1'b1;
                else                    ok_c = rcd_ok_c[cmd_bank];
            end
            OP_WR: begin
                if (!is_open[cmd_bank]) illegal_c = 1'b1;
                else                    ok_c = rcd_ok_c[cmd_bank] & ~rd_busy_c;
            end
            OP_PRE: begin
                if (!is_open[cmd_bank]) illegal_c = 1'b1;
                else                    ok_c = ras_ok_c[cmd_bank] & wr_ok_c[cmd_bank];
            end
            OP_PREA: ok_c = &(~is_open | (ras_ok_c & wr_ok_c));
            OP_REF, OP_MRS: begin
                if (|is_open) illegal_c = 1'b1;
                else          ok_c = &rp_ok_c;
            end
            default: ;
        endcase
    end

    // NOP is always accepted; everything else waits for the refresh/MRS window
    assign cmd_ready = (cmd_op == OP_NOP) | (glb_idle_c & (ok_c | illegal_c));
    assign fire_c    = cmd_valid & cmd_ready & (cmd_op != OP_NOP);
    assign issue_c   = fire_c & ~illegal_c;
    assign drop_c    = fire_c & illegal_c;

    assign act_ev_c = (issue_c && cmd_op == OP_ACT) ? bank_sel_c : '0;
    assign wr_ev_c  = (issue_c && cmd_op == OP_WR)  ? bank_sel_c : '0;
    // PREA only closes banks that are actually open
    assign pre_ev_c = (issue_c && cmd_op == OP_PRE)  ? bank_sel_c :
                      (issue_c && cmd_op == OP_PREA) ? is_open    : '0;

    for (genvar i = 0; i < int'(NB); i++) begin : g_bank
        sdram_bank_timer #(
            .T_RCD (T_RCD),
            .T_RP  (T_RP),
            .T_RAS (T_RAS),
            .T_RC  (T_RC),
            .T_WR  (T_WR)
        ) u_timer (
            .clk      (clk),
            .rst      (rst),
            .act      (act_ev_c[i]),
            .wr       (wr_ev_c[i]),
            .pre      (pre_ev_c[i]),
            .is_open  (is_open[i]),
            .rcd_ok_c (rcd_ok_c[i]),
            .ras_ok_c (ras_ok_c[i]),
            .rc_ok_c  (rc_ok_c[i]),
            .rp_ok_c  (rp_ok_c[i]),
            .wr_ok_c  (wr_ok_c[i])
        );
    end

    // Pin drive, global refresh/MRS counter and read-return pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            cke         <= 1'b0;
            cs_n        <= 1'b0;
            {ras_n, cas_n, we_n} <= CMD_NOP;
            ba          <= '0;
            addr        <= '0;
            dqm         <= '1;
            dq_out      <= '0;
            dq_oe       <= 1'b0;
            err_illegal <= 1'b0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
            rd_pipe     <= '0;
            glb_cnt     <= '0;
        end else begin
            cke         <= 1'b1;
            cs_n        <= 1'b0;
            {ras_n, cas_n, we_n} <= CMD_NOP;
            ba          <= '0;
            addr        <= '0;
            dqm         <= '1;
            dq_out      <= '0;
            dq_oe       <= 1'b0;
            err_illegal <= drop_c;

            // Bit k marks a read whose pin cycle was k cycles ago; the top bit
            // lines up with the data arriving on dq_in.
            rd_pipe  <= {rd_pipe[CAS_LAT-1:0], issue_c && (cmd_op == OP_RD)};
            rd_valid <= rd_pipe[CAS_LAT];
            if (rd_pipe[CAS_LAT]) begin
                rd_data <= dq_in;
            end

            if (issue_c && cmd_op == OP_REF) begin
                glb_cnt <= RFC_LD;
            end else if (issue_c && cmd_op == OP_MRS) begin
                glb_cnt <= MRD_LD;
            end else if (!glb_idle_c) begin
                glb_cnt <= glb_cnt - GLB_W'(1);
            end

            if (issue_c) begin
                case (cmd_op)
                    OP_ACT: begin
                        {ras_n, cas_n, we_n} <= CMD_ACT;
                        ba   <= cmd_bank;
                        addr <= cmd_addr;
                    end
                    OP_RD: begin
                        {ras_n, cas_n, we_n} <= CMD_RD;
                        ba   <= cmd_bank;
                        addr <= col_c;
                        dqm  <= '0;
                    end
                    OP_WR: begin
                        {ras_n, cas_n, we_n} <= CMD_WR;
                        ba     <= cmd_bank;
                        addr   <= col_c;
                        dqm    <= ~cmd_wmask;
                        dq_out <= cmd_wdata;
                        dq_oe  <= 1'b1;
                    end
                    OP_PRE: begin
                        {ras_n, cas_n, we_n} <= CMD_PRE;
                        ba <= cmd_bank;
                    end
                    OP_PREA: begin
                        {ras_n, cas_n, we_n} <= CMD_PRE;
                        addr <= A10;
                    end
                    OP_REF: {ras_n, cas_n, we_n} <= CMD_REF;
                    OP_MRS: begin
                        {ras_n, cas_n, we_n} <= CMD_MRS;
                        addr <= cmd_addr;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sdram_cmd_phy.sv
// Directed self-checking bench for sdram_cmd_phy with default parameters.
module tb_sdram_cmd_phy;
    import sdram_pkg::*;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ROW_W  = 13;
    localparam int unsigned BANK_W = 2;
    localparam int unsigned MW     = DATA_W / 8;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [63:0] P_NOP = 64'h7;
    localparam logic [63:0] P_ACT = 64'h3;
    localparam logic [63:0] P_RD  = 64'h5;
    localparam logic [63:0] P_WR  = 64'h4;
    localparam logic [63:0] P_PRE = 64'h2;
    localparam logic [63:0] P_REF = 64'h1;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    op_e               cmd_op;
    logic [BANK_W-1:0] cmd_bank;
    logic [ROW_W-1:0]  cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic [MW-1:0]     cmd_wmask;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              err_illegal;
    logic              cke, cs_n, ras_n, cas_n, we_n;
    logic [BANK_W-1:0] ba;
    logic [ROW_W-1:0]  addr;
    logic [MW-1:0]     dqm;
    logic [DATA_W-1:0] dq_out;
    logic [DATA_W-1:0] dq_in;
    logic              dq_oe;
    logic [3:0]        pins;

    int checks = 0;
    int errors = 0;

    assign pins = {cs_n, ras_n, cas_n, we_n};

    always #5 clk = ~clk;

    sdram_cmd_phy dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_bank    (cmd_bank),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_wmask   (cmd_wmask),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .err_illegal (err_illegal),
        .cke         (cke),
        .cs_n        (cs_n),
        .ras_n       (ras_n),
        .cas_n       (cas_n),
        .we_n        (we_n),
        .ba          (ba),
        .addr        (addr),
        .dqm         (dqm),
        .dq_out      (dq_out),
        .dq_in       (dq_in),
        .dq_oe       (dq_oe)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input op_e op, input logic [BANK_W-1:0] b, input logic [ROW_W-1:0] a);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_bank  = b;
        cmd_addr  = a;
    endtask

    task automatic idle();
        cmd_valid = 1'b0;
        cmd_op    = OP_NOP;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        idle();
        cmd_bank  = '0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wmask = '0;
        dq_in     = '0;

        // Reset values
        repeat (3) tick();
        chk("rst_cke",   64'(cke), 64'h0);
        chk("rst_pins",  64'(pins), P_NOP);
        chk("rst_dqm",   64'(dqm), 64'hF);
        chk("rst_dq_oe", 64'(dq_oe), 64'h0);
        chk("rst_rdv",   64'(rd_valid), 64'h0);
        chk("rst_err",   64'(err_illegal), 64'h0);
        chk("rst_baddr", 64'({ba, addr, dq_out, rd_data}), 64'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("cke_up",   64'(cke), 64'h1);
        chk("idle_nop", 64'(pins), P_NOP);

        // Cycle 0: ACT bank 1 row 0x155
        offer(OP_ACT, 2'd1, 13'h155);
        #1 chk("act_ready", 64'(cmd_ready), 64'h1);
        tick();                                     // cycle 1
        chk("act_pins", 64'(pins), P_ACT);
        chk("act_ba",   64'(ba), 64'h1);
        chk("act_addr", 64'(addr), 64'h155);
        offer(OP_RD, 2'd1, 13'h020);
        #1 chk("rd_rcd_c1", 64'(cmd_ready), 64'h0);
        tick();                                     // cycle 2
        chk("rd_rcd_c2", 64'(cmd_ready), 64'h0);
        tick();                                     // cycle 3
        chk("rd_ready_c3", 64'(cmd_ready), 64'h1);
        tick();                                     // cycle 4
        idle();
        chk("rd_pins", 64'(pins), P_RD);
        chk("rd_ba",   64'(ba), 64'h1);
        chk("rd_addr", 64'(addr), 64'h020);
        chk("rd_dqm",  64'(dqm), 64'h0);
        tick();                                     // cycle 5
        tick();                                     // cycle 6
        chk("rd_early6", 64'(rd_valid), 64'h0);
        tick();                                     // cycle 7
        dq_in = 32'hDEADBEEF;
        chk("rd_early7", 64'(rd_valid), 64'h0);
        tick();                                     // cycle 8
        dq_in = '0;
        chk("rd_valid", 64'(rd_valid), 64'h1);
        chk("rd_data",  64'(rd_data), 64'hDEADBEEF);
        tick();                                     // cycle 9
        chk("rd_pulse", 64'(rd_valid), 64'h0);

        // WR bank 1 with partial mask, then PRE held by write recovery
        offer(OP_WR, 2'd1, 13'h004);
        cmd_wdata = 32'hA5A5A5A5;
        cmd_wmask = 4'b0011;
        #1 chk("wr_ready", 64'(cmd_ready), 64'h1);
        tick();                                     // cycle 10
        chk("wr_pins",  64'(pins), P_WR);
        chk("wr_addr",  64'(addr), 64'h004);
        chk("wr_dqm",   64'(dqm), 64'hC);
        chk("wr_oe",    64'(dq_oe), 64'h1);
        chk("wr_dqout", 64'(dq_out), 64'hA5A5A5A5);
        offer(OP_PRE, 2'd1, 13'h0);
        #1 chk("pre_twr_blk", 64'(cmd_ready), 64'h0);
        tick();                                     // cycle 11
        chk("wr_oe_off", 64'(dq_oe), 64'h0);
        chk("wr_nop",    64'(pins), P_NOP);
        chk("pre_ready", 64'(cmd_ready), 64'h1);
        tick();                                     // cycle 12
        chk("pre_pins", 64'(pins), P_PRE);
        chk("pre_ba",   64'(ba), 64'h1);
        chk("pre_addr", 64'(addr), 64'h0);

        // RD to idle bank 2 is dropped
        offer(OP_RD, 2'd2, 13'h010);
        #1 chk("ill_ready", 64'(cmd_ready), 64'h1);
        tick();                                     // cycle 13
        idle();
        chk("ill_err",  64'(err_illegal), 64'h1);
        chk("ill_pins", 64'(pins), P_NOP);
        tick();
        chk("ill_err_pulse", 64'(err_illegal), 64'h0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("ill_no_rdv", 64'(rd_valid), 64'h0);
        end

        // Cycle R: REF with all banks idle, ACT blocked for T_RFC
        offer(OP_REF, 2'd0, 13'h0);
        #1 chk("ref_ready", 64'(cmd_ready), 64'h1);
        tick();                                     // R+1
        chk("ref_pins", 64'(pins), P_REF);
        offer(OP_ACT, 2'd0, 13'h0AA);
        #1 chk("ref_blk", 64'(cmd_ready), 64'h0);
        for (int i = 2; i < 10; i++) begin
            tick();
            chk("ref_blk", 64'(cmd_ready), 64'h0);
        end
        tick();                                     // R+10
        chk("ref_done", 64'(cmd_ready), 64'h1);
        tick();                                     // R+11
        chk("act0_pins", 64'(pins), P_ACT);
        chk("act0_addr", 64'(addr), 64'h0AA);

        // REF with bank 0 open is state-illegal
        offer(OP_REF, 2'd0, 13'h0);
        #1 chk("ref_open_ready", 64'(cmd_ready), 64'h1);
        tick();                                     // R+12
        chk("ref_open_err",  64'(err_illegal), 64'h1);
        chk("ref_open_pins", 64'(pins), P_NOP);

        // PRE bank 0 held by T_RAS from ACT at R+10
        offer(OP_PRE, 2'd0, 13'h0);
        #1 chk("pre_tras_blk", 64'(cmd_ready), 64'h0);
        for (int i = 13; i < 17; i++) begin
            tick();
            chk("pre_tras_blk", 64'(cmd_ready), 64'h0);
        end
        tick();                                     // R+17
        chk("pre_tras_ok", 64'(cmd_ready), 64'h1);
        tick();                                     // R+18
        chk("pre0_pins", 64'(pins), P_PRE);

        // Reset while a read is in flight
        offer(OP_ACT, 2'd3, 13'h1F0);
        #1 chk("act3_ready", 64'(cmd_ready), 64'h1);
        tick();                                     // R+19
        offer(OP_RD, 2'd3, 13'h008);
        tick();                                     // R+20
        tick();                                     // R+21
        chk("rd3_ready", 64'(cmd_ready), 64'h1);
        tick();                                     // R+22
        idle();
        chk("rd3_pins", 64'(pins), P_RD);
        tick();                                     // R+23
        rst = 1'b1;
        tick();                                     // R+24
        rst = 1'b0;
        chk("mid_rst_cke",  64'(cke), 64'h0);
        chk("mid_rst_pins", 64'(pins), P_NOP);
        offer(OP_ACT, 2'd3, 13'h1F0);
        #1 chk("act_after_rst", 64'(cmd_ready), 64'h1);
        tick();                                     // R+25
        idle();
        chk("act_after_pins", 64'(pins), P_ACT);
        chk("act_after_ba",   64'(ba), 64'h3);
        chk("act_after_err",  64'(err_illegal), 64'h0);
        chk("act_after_cke",  64'(cke), 64'h1);
        tick();                                     // R+26
        chk("flushed_rdv", 64'(rd_valid), 64'h0);
        tick();                                     // R+27
        chk("flushed_rdv", 64'(rd_valid), 64'h0);

        // Back-to-back reads, and WR blocked while they are in flight
        offer(OP_RD, 2'd3, 13'h001);
        #1 chk("b2b_rd1_ready", 64'(cmd_ready), 64'h1);
        tick();                                     // R+28
        offer(OP_RD, 2'd3, 13'h002);
        #1 chk("b2b_rd2_ready", 64'(cmd_ready), 64'h1);
        chk("b2b_rd1_addr", 64'(addr), 64'h001);
        tick();                                     // R+29
        chk("b2b_rd2_addr", 64'(addr), 64'h002);
        offer(OP_WR, 2'd3, 13'h003);
        #1 chk("wr_turn_blk", 64'(cmd_ready), 64'h0);
        idle();
        tick();                                     // R+30
        chk("b2b_early", 64'(rd_valid), 64'h0);
        tick();                                     // R+31
        dq_in = 32'h11111111;
        chk("b2b_early", 64'(rd_valid), 64'h0);
        tick();                                     // R+32
        dq_in = 32'h22222222;
        chk("b2b_v1", 64'(rd_valid), 64'h1);
        chk("b2b_d1", 64'(rd_data), 64'h11111111);
        tick();                                     // R+33
        dq_in = '0;
        chk("b2b_v2", 64'(rd_valid), 64'h1);
        chk("b2b_d2", 64'(rd_data), 64'h22222222);
        tick();                                     // R+34
        chk("b2b_end", 64'(rd_valid), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_cmd_phy.md
Name: sdram_cmd_phy

Overview:
Parametrised SDRAM command/pin engine. It sits between the controller's command scheduler and the SDRAM pin bundle (cke, cs_n, ras_n, cas_n, we_n, ba, addr, dqm, dq_out, dq_in, dq_oe). It accepts decoded commands over a valid/ready handshake and tracks per-bank open/idle state. It enforces JEDEC timing, drives registered pins and returns read data after CAS latency.

Parameters:
DATA_W, 32, DQ width; must be a multiple of 8
ROW_W, 13, row/pin address width; must be >= 11
COL_W, 9, column width; must be <= 10 (addr[10] reserved)
BANK_W, 2, bank address width; NB = 2**BANK_W
CAS_LAT, 3, read latency in cycles; legal values 2 or 3
T_RCD, 3, ACT to RD/WR, same bank
T_RP, 3, PRE to ACT, same bank
T_RAS, 7, ACT to PRE, same bank
T_RC, 10, ACT to ACT, same bank
T_WR, 2, WR to PRE, same bank
T_RFC, 10, REF to any command
T_MRD, 2, MRS to any command

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted this cycle when both are high
cmd_op  in  3  sdram_pkg::op_e: NOP, ACT, RD, WR, PRE, PREA, REF, MRS
cmd_bank  in  BANK_W  target bank
cmd_addr  in  ROW_W  row (ACT), column in low COL_W bits (RD/WR), mode value (MRS)
cmd_wdata  in  DATA_W  write data
cmd_wmask  in  DATA_W/8  byte enables, 1 = write byte
rd_valid  out  1  read data valid, one-cycle pulse
rd_data  out  DATA_W  read data
err_illegal  out  1  one-cycle pulse: state-illegal command dropped
cke, cs_n, ras_n, cas_n, we_n  out  1 each  SDRAM control pins
ba  out  BANK_W  bank pins
addr  out  ROW_W  address pins
dqm  out  DATA_W/8  data mask pins, 1 = masked
dq_out  out  DATA_W  write data to pad
dq_in  in  DATA_W  read data from pad
dq_oe  out  1  pad output enable

Behaviour:
- Reset: cke=0, pins show NOP (cs_n=0, ras_n=cas_n=we_n=1), ba=0, addr=0, dqm=all-ones, dq_out=0, dq_oe=0, rd_valid=0, rd_data=0, err_illegal=0. All banks idle, all timers 0, read pipeline flushed. cke=1 from the first cycle after rst deasserts.
- Reset mid-operation takes precedence over everything: in-flight reads are discarded (no rd_valid) and open banks are forgotten.
- Pins are registered. A handshake at edge E drives the command encoding for exactly one cycle after E, then NOP.
- Timing: each T_x is the minimum handshake-to-handshake spacing. The dependent command's earliest handshake is T_x cycles after the first command's handshake.
- Per-bank state: IDLE and OPEN. ACT moves IDLE to OPEN. PRE and PREA move OPEN to IDLE.
- Per-bank counters: tRCD, tRAS, tRC, tRP, tWR.
- Global counter: tRFC/tMRD, which blocks all ops while nonzero.
- cmd_ready is combinational from state and counters; it never depends on cmd_valid.
  - ACT: bank IDLE, tRP=0, tRC=0.
  - RD/WR: bank OPEN, tRCD=0.
  - PRE: bank OPEN, tRAS=0, tWR=0.
  - PREA: all OPEN banks have tRAS=0 and tWR=0.
  - REF/MRS: all banks IDLE and all tRP=0.
  - WR additionally requires no read in flight (bus turnaround).
  - RD is never blocked by a preceding WR.
- State-illegal commands are accepted with cmd_ready=1 when the global counter is 0, drop without driving pins, and pulse err_illegal. They are: ACT to an OPEN bank; RD/WR/PRE to an IDLE bank; REF/MRS with any bank OPEN. NOP is always ready and has no effect.
- Pin encodings:
  - RD/WR: addr[COL_W-1:0]=column, addr[10]=0, other bits 0.
  - PRE: addr[10]=0. PREA: addr[10]=1.
  - MRS: ba=0, addr=cmd_addr.
  - WR: dq_out=cmd_wdata, dqm=~cmd_wmask, dq_oe=1, all in the WR pin cycle.
  - RD: dqm=0.
- Read path: a shift register of depth CAS_LAT+1 tags read slots. dq_in is sampled CAS_LAT cycles after the RD pin cycle. rd_valid and rd_data appear CAS_LAT+2 cycles after the RD handshake.
- Back-to-back RDs every cycle are supported and produce consecutive rd_valid.
- Simultaneous timer expiry and request: a counter reaching 0 in cycle C permits handshake in cycle C.

Decomposition:
- sdram_pkg holds:
  - op_e;
  - the pin-encoding constants (CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF, CMD_MRS as {ras_n, cas_n, we_n});
  - the counter-width helper function.
- One sub-module, sdram_bank_timer: per-bank state and counters, instantiated NB times by generate.

Test Plan:
- rst held 5 cycles then released -> cke=0 and NOP/dqm=all-ones during reset; cke=1 next cycle; ACT ready.
- ACT bank1 row 0x155 at cycle 0, RD col 0x020 offered cycle 1 -> cmd_ready=0 cycles 1-2, accepted cycle 3. Pins in cycle 4: cas_n=0, ras_n=1, we_n=1, ba=1, addr=0x020. dq_in=0xDEADBEEF in cycle 7 -> rd_valid with 0xDEADBEEF in cycle 8.
- WR bank1 wdata 0xA5A5A5A5, mask 4'b0011 -> one pin cycle with dqm=4'b1100, dq_oe=1, dq_out=0xA5A5A5A5. PRE offered next cycle -> held until max(T_RAS from ACT, T_WR).
- RD to IDLE bank 2 -> accepted, err_illegal pulses 1 cycle, pins stay NOP, no rd_valid.
- All banks idle, REF at cycle 0 -> ACT blocked until cycle 10. REF with bank 0 OPEN -> err_illegal.
- RD accepted, rst asserted 2 cycles later -> no rd_valid ever, bank returns IDLE, ACT to same bank accepted immediately after reset.
